// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: pin command encodings {cs_n, ras_n, cas_n, we_n}
// and the controller state enumeration.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

endpackage

// File: rtl/sdram_dq_io.sv
// Tri-state driver for the SDRAM data bus and the free-running read capture register.
module sdram_dq_io #(
  parameter int DQ_W = 16
) (
  input  logic            sclk,
  input  logic            srst_n,
  input  logic            oe_d,
  input  logic [DQ_W-1:0] data_d,
  output logic [DQ_W-1:0] rd_data,
  inout  wire  [DQ_W-1:0] sdram_dq
);

  logic            oe_q;
  logic [DQ_W-1:0] data_q;

  // NOTE: the async reset drops oe_q at once, so the bus releases mid-burst
  // without waiting for a clock edge.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      oe_q    <= 1'b0;
      data_q  <= '0;
      rd_data <= '0;
    end else begin
      oe_q    <= oe_d;
      data_q  <= data_d;
      rd_data <= sdram_dq;
    end
  end

  assign sdram_dq = oe_q ? data_q : {DQ_W{1'bz}};

endmodule

// File: rtl/sdram_ctrl_arbit.sv
// SDRAM controller core: init sequencing, refresh/write/read arbitration and
// registered pin drive from the granted engine.
module sdram_ctrl_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W        = 12,
  parameter int BANK_W        = 2,
  parameter int DQ_W          = 16,
  parameter int REF_DEFER_MAX = 64
) (
  input  logic              sclk,
  input  logic              srst_n,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [BANK_W-1:0] init_bank,
  input  logic              flag_init_end,
  input  logic              aref_ask,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_ask,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [DQ_W-1:0]   wr_data,
  input  logic              wr_dq_oe,
  input  logic              rd_ask,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BANK_W-1:0] rd_bank,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [DQ_W-1:0]   rd_data,
  output logic              ref_overdue,
  output logic              sdram_clk,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DQ_W/8-1:0] sdram_dqm,
  inout  wire  [DQ_W-1:0]   sdram_dq
);

  // Counter must hold REF_DEFER_MAX+1 so "exceeds" is representable.
  localparam int              CNT_W   = $clog2(REF_DEFER_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REF_DEFER_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(REF_DEFER_MAX + 1);

  state_t            state;
  logic              aref_pend;
  logic              last_grant;
  logic [CNT_W-1:0]  defer_cnt;
  logic [CNT_W-1:0]  defer_inc;
  logic [3:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BANK_W-1:0] bank_q;
  logic              oe_d;

  assign defer_inc = (defer_cnt == CNT_SAT) ? defer_cnt : defer_cnt + 1'b1;

  // NOTE: all state uses non-blocking assignment; where two assignments to the
  // same register hit one edge, the later one (AREF entry clears) wins.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state       <= INIT;
      aref_pend   <= 1'b0;
      last_grant  <= 1'b1;
      defer_cnt   <= '0;
      ref_overdue <= 1'b0;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      bank_q      <= '0;
    end else begin
      case (state)
        INIT:    begin cmd_q <= init_cmd; addr_q <= init_addr; bank_q <= init_bank; end
        AREF:    begin cmd_q <= aref_cmd; addr_q <= aref_addr; bank_q <= '0;        end
        WRITE:   begin cmd_q <= wr_cmd;   addr_q <= wr_addr;   bank_q <= wr_bank;   end
        READ:    begin cmd_q <= rd_cmd;   addr_q <= rd_addr;   bank_q <= rd_bank;   end
        default: begin cmd_q <= CMD_NOP;  addr_q <= '0;        bank_q <= '0;        end
      endcase

      if (aref_ask && state != INIT) aref_pend <= 1'b1;

      if (aref_pend) begin
        defer_cnt <= defer_inc;
        if (defer_inc > CNT_MAX) ref_overdue <= 1'b1;
      end

      // A same-cycle aref_ask in ARBIT is granted directly, ahead of wr/rd.
      case (state)
        INIT:  if (flag_init_end) state <= ARBIT;
        ARBIT: begin
          if (aref_pend || aref_ask) begin
            state       <= AREF;
            aref_pend   <= 1'b0;
            defer_cnt   <= '0;
            ref_overdue <= 1'b0;
          end else if (wr_ask && (!rd_ask || last_grant)) begin
            state      <= WRITE;
            last_grant <= 1'b0;
          end else if (rd_ask) begin
            state      <= READ;
            last_grant <= 1'b1;
          end
        end
        AREF:    if (aref_end) state <= ARBIT;
        WRITE:   if (wr_end)   state <= ARBIT;
        READ:    if (rd_end)   state <= ARBIT;
        default: state <= INIT;
      endcase
    end
  end

  assign aref_en = (state == AREF);
  assign wr_en   = (state == WRITE);
  assign rd_en   = (state == READ);
  assign oe_d    = (state == WRITE) && wr_dq_oe;

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_addr = addr_q;
  assign sdram_bank = bank_q;
  assign sdram_clk  = ~sclk;
  assign sdram_cke  = 1'b1;
  assign sdram_dqm  = '0;

  sdram_dq_io #(.DQ_W(DQ_W)) u_dq_io (
    .sclk     (sclk),
    .srst_n   (srst_n),
    .oe_d     (oe_d),
    .data_d   (wr_data),
    .rd_data  (rd_data),
    .sdram_dq (sdram_dq)
  );

endmodule
